// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port controller between the byte-wide unified RAM and its
// two requesters (instruction fetcher and load/store buffer).
//
// Splits 1/2/4-byte little-endian accesses into byte transfers, arbitrates
// store > load > fetch, and returns the assembled word with a one-cycle
// success pulse. A mispredict flush drops fetch/load work; stores always finish.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   rdy                 global enable; low freezes state and outputs
//   jump_wrong          mispredict flush
//   lsb_read_signal     load request (level), lsb_write_signal store request (level)
//   requiring_length    access size in bytes (1, 2, 4)
//   to_mem_addr/data    LSB byte address / store data
//   mem_load_success    load data valid pulse, from_mem_data zero-extended result
//   mem_store_success   store finished pulse
//   if_read_signal      fetch request (level), if_addr fetch address
//   if_success/if_instr fetch done pulse / fetched word
//   mem_din/mem_dout    RAM read data (1-cycle latency) / RAM write data
//   mem_a, mem_wr       RAM address, 1 = write
//   io_buffer_full      IO write back-pressure
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting; grants highest-priority request
// S_READ  | issuing byte addresses and capturing returned bytes
// S_WRITE | writing one byte per cycle, stalls on full IO buffer
// S_COOL  | one idle cycle so the requester can drop its request

module mem_ctrl #(
    parameter logic [1:0]  IO_ADDR_HI  = 2'b11,
    parameter int unsigned FETCH_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        jump_wrong,
    input  logic        lsb_read_signal,
    input  logic        lsb_write_signal,
    input  logic [2:0]  requiring_length,
    input  logic [31:0] to_mem_addr,
    input  logic [31:0] to_mem_data,
    output logic        mem_load_success,
    output logic        mem_store_success,
    output logic [31:0] from_mem_data,
    input  logic        if_read_signal,
    input  logic [31:0] if_addr,
    output logic        if_success,
    output logic [31:0] if_instr,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_COOL} state_t;

    localparam logic [2:0] FETCH_LEN = 3'(FETCH_BYTES);

    state_t      r_state;
    logic        r_is_fetch;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [31:0] r_buf;
    logic [2:0]  r_len;
    logic [2:0]  r_k;      // next byte index to issue
    logic [2:0]  r_cap;    // next byte lane to capture
    logic        r_v1;     // address issued on the previous active edge
    logic        r_v2;     // mem_din now holds data for lane r_cap
    logic        r_stall;  // previous edge had rdy low
    logic [31:0] r_mem_a;
    logic [7:0]  r_mem_dout;
    logic        r_mem_wr;
    logic        r_if_success;
    logic        r_load_success;
    logic        r_store_success;
    logic [31:0] r_from_mem_data;
    logic [31:0] r_if_instr;

    logic [31:0] w_word;
    logic [7:0]  w_wbyte;
    logic        w_io_stall;

    // Word with the byte arriving this cycle merged into lane r_cap.
    always_comb begin
        w_word = r_buf;
        case (r_cap[1:0])
            2'd0:    w_word[7:0]   = mem_din;
            2'd1:    w_word[15:8]  = mem_din;
            2'd2:    w_word[23:16] = mem_din;
            default: w_word[31:24] = mem_din;
        endcase
    end

    always_comb begin
        case (r_k[1:0])
            2'd0:    w_wbyte = r_data[7:0];
            2'd1:    w_wbyte = r_data[15:8];
            2'd2:    w_wbyte = r_data[23:16];
            default: w_wbyte = r_data[31:24];
        endcase
    end

    assign w_io_stall = io_buffer_full && (r_addr[17:16] == IO_ADDR_HI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_is_fetch      <= 1'b0;
            r_addr          <= '0;
            r_data          <= '0;
            r_buf           <= '0;
            r_len           <= '0;
            r_k             <= '0;
            r_cap           <= '0;
            r_v1            <= 1'b0;
            r_v2            <= 1'b0;
            r_stall         <= 1'b0;
            r_mem_a         <= '0;
            r_mem_dout      <= '0;
            r_mem_wr        <= 1'b0;
            r_if_success    <= 1'b0;
            r_load_success  <= 1'b0;
            r_store_success <= 1'b0;
            r_from_mem_data <= '0;
            r_if_instr      <= '0;
        end else begin
            // Only bookkeeping that runs while frozen: lets READ know the RAM
            // pipeline went stale and must be re-primed.
            r_stall <= !rdy;
            if (rdy) begin
                r_if_success    <= 1'b0;
                r_load_success  <= 1'b0;
                r_store_success <= 1'b0;
                case (r_state)
                    S_IDLE: begin
                        r_mem_wr <= 1'b0;
                        if (!jump_wrong) begin
                            if (lsb_write_signal) begin
                                r_is_fetch <= 1'b0;
                                r_addr     <= to_mem_addr;
                                r_data     <= to_mem_data;
                                r_len      <= requiring_length;
                                r_state    <= S_WRITE;
                                if (io_buffer_full && (to_mem_addr[17:16] == IO_ADDR_HI)) begin
                                    r_k <= 3'd0;
                                end else begin
                                    r_mem_wr   <= 1'b1;
                                    r_mem_a    <= to_mem_addr;
                                    r_mem_dout <= to_mem_data[7:0];
                                    r_k        <= 3'd1;
                                end
                            end else if (lsb_read_signal || if_read_signal) begin
                                r_is_fetch <= !lsb_read_signal;
                                r_addr     <= lsb_read_signal ? to_mem_addr : if_addr;
                                r_len      <= lsb_read_signal ? requiring_length : FETCH_LEN;
                                r_mem_a    <= lsb_read_signal ? to_mem_addr : if_addr;
                                r_state    <= S_READ;
                                r_k        <= 3'd1;
                                r_cap      <= 3'd0;
                                r_buf      <= '0;
                                r_v1       <= 1'b1;
                                r_v2       <= 1'b0;
                            end
                        end
                    end
                    S_READ: begin
                        if (jump_wrong) begin
                            r_state <= S_IDLE;
                            r_v1    <= 1'b0;
                            r_v2    <= 1'b0;
                        end else if (r_stall) begin
                            // mem_din no longer matches the pipeline: restart
                            // from the oldest lane not yet captured.
                            r_mem_a <= r_addr + {29'd0, r_cap};
                            r_k     <= r_cap + 3'd1;
                            r_v1    <= 1'b1;
                            r_v2    <= 1'b0;
                        end else begin
                            r_v2 <= r_v1;
                            if (r_k < r_len) begin
                                r_mem_a <= r_addr + {29'd0, r_k};
                                r_k     <= r_k + 3'd1;
                                r_v1    <= 1'b1;
                            end else begin
                                r_v1 <= 1'b0;
                            end
                            if (r_v2) begin
                                r_buf <= w_word;
                                r_cap <= r_cap + 3'd1;
                                if (r_cap == r_len - 3'd1) begin
                                    if (r_is_fetch) begin
                                        r_if_instr   <= w_word;
                                        r_if_success <= 1'b1;
                                    end else begin
                                        r_from_mem_data <= w_word;
                                        r_load_success  <= 1'b1;
                                    end
                                    r_state <= S_COOL;
                                    r_v1    <= 1'b0;
                                    r_v2    <= 1'b0;
                                end
                            end
                        end
                    end
                    S_WRITE: begin
                        // r_k reaches r_len only on the edge that issued the
                        // last byte, so this edge commits it.
                        if (r_k == r_len) begin
                            r_mem_wr        <= 1'b0;
                            r_store_success <= 1'b1;
                            r_state         <= S_COOL;
                        end else if (w_io_stall) begin
                            r_mem_wr <= 1'b0;
                        end else begin
                            r_mem_wr   <= 1'b1;
                            r_mem_a    <= r_addr + {29'd0, r_k};
                            r_mem_dout <= w_wbyte;
                            r_k        <= r_k + 3'd1;
                        end
                    end
                    S_COOL: begin
                        r_mem_wr <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                    default: begin
                        r_mem_wr <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign mem_a             = r_mem_a;
    assign mem_dout          = r_mem_dout;
    assign mem_wr            = r_mem_wr;
    assign if_success        = r_if_success;
    assign if_instr          = r_if_instr;
    assign mem_load_success  = r_load_success;
    assign mem_store_success = r_store_success;
    assign from_mem_data     = r_from_mem_data;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        jump_wrong = 1'b0;
    logic        lsb_read_signal = 1'b0;
    logic        lsb_write_signal = 1'b0;
    logic [2:0]  requiring_length = 3'd0;
    logic [31:0] to_mem_addr = '0;
    logic [31:0] to_mem_data = '0;
    logic        if_read_signal = 1'b0;
    logic [31:0] if_addr = '0;
    logic        io_buffer_full = 1'b0;
    logic [7:0]  mem_din = '0;
    logic        mem_load_success, mem_store_success, if_success, mem_wr;
    logic [31:0] from_mem_data, if_instr, mem_a;
    logic [7:0]  mem_dout;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
        .lsb_read_signal(lsb_read_signal), .lsb_write_signal(lsb_write_signal),
        .requiring_length(requiring_length), .to_mem_addr(to_mem_addr),
        .to_mem_data(to_mem_data), .mem_load_success(mem_load_success),
        .mem_store_success(mem_store_success), .from_mem_data(from_mem_data),
        .if_read_signal(if_read_signal), .if_addr(if_addr), .if_success(if_success),
        .if_instr(if_instr), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
        .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // RAM model: 4 KiB aliased, registered read, write on mem_wr.
    logic [7:0] ram [0:4095];
    initial begin : ram_proc
        for (int i = 0; i < 4096; i++) ram[i] = 8'(i * 37 + 11);
        ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
        ram[12'h104] = 8'h93; ram[12'h105] = 8'h00; ram[12'h106] = 8'h10; ram[12'h107] = 8'h00;
        ram[12'h200] = 8'hFF; ram[12'h201] = 8'h80; ram[12'h202] = 8'h11; ram[12'h203] = 8'h22;
        ram[12'h300] = 8'hA5;
        ram[12'hFFF] = 8'h12;
        forever begin
            @(posedge clk);
            mem_din <= ram[mem_a[11:0]];
            if (mem_wr) ram[mem_a[11:0]] = mem_dout;
        end
    end

    // Transaction model: little-endian word of n bytes from the RAM image.
    function automatic logic [31:0] rd_word(input logic [31:0] a, input int n);
        logic [31:0] w;
        logic [31:0] ai;
        w = '0;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            w = w | (32'(ram[ai[11:0]]) << (8 * i));
        end
        return w;
    endfunction

    // Expected events per kind: 0 fetch, 1 load, 2 store (data = write-cycle count).
    bit          exp_v [3];
    int          exp_due [3];
    logic [31:0] exp_dat [3];
    int          last_pulse [3];
    int          wr_cnt = 0;
    int          free_edge = 0;

    always @(negedge clk) begin : compare
        logic [2:0] p;
        if (!rst) begin
            p = {mem_store_success, mem_load_success, if_success};
            if (mem_wr) wr_cnt++;
            if (!exp_v[2]) chk("mem_wr_low", {31'd0, mem_wr}, 32'd0);
            for (int k = 0; k < 3; k++) begin
                if (exp_v[k] && (cyc == exp_due[k] || (exp_due[k] < 0 && p[k]))) begin
                    chk($sformatf("pulse_k%0d", k), {31'd0, p[k]}, 32'd1);
                    case (k)
                        0:       chk("if_instr", if_instr, exp_dat[0]);
                        1:       chk("from_mem_data", from_mem_data, exp_dat[1]);
                        default: chk("store_wr_cycles", 32'(wr_cnt), exp_dat[2]);
                    endcase
                    exp_v[k] = 1'b0;
                    last_pulse[k] = cyc;
                end else begin
                    chk($sformatf("no_pulse_k%0d", k), {31'd0, p[k]}, 32'd0);
                end
            end
        end
    end

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    function automatic int next_grant();
        return (cyc + 1 > free_edge) ? cyc + 1 : free_edge;
    endfunction

    // lat < 0: completion time not pinned, only the result is checked.
    task automatic expect_op(input int kind, input int grant, input int lat, input logic [31:0] dat);
        exp_v[kind]   = 1'b1;
        exp_due[kind] = (lat < 0) ? -1 : grant + lat;
        exp_dat[kind] = dat;
        if (kind == 2) wr_cnt = 0;
        if (lat >= 0) free_edge = grant + lat + 2;
    endtask

    task automatic wait_done(input int kind);
        int n;
        n = 0;
        while (exp_v[kind] && n < 60) begin
            step();
            n++;
        end
        chk($sformatf("done_k%0d", kind), {31'd0, exp_v[kind]}, 32'd0);
        if (exp_v[kind]) exp_v[kind] = 1'b0;
        else free_edge = last_pulse[kind] + 2;
    endtask

    task automatic start_load(input logic [31:0] a, input logic [2:0] len);
        lsb_read_signal = 1'b1; to_mem_addr = a; requiring_length = len;
    endtask

    task automatic start_store(input logic [31:0] a, input logic [2:0] len, input logic [31:0] d);
        lsb_write_signal = 1'b1; to_mem_addr = a; requiring_length = len; to_mem_data = d;
    endtask

    initial begin : main
        int g;
        int g2;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_if_success", {31'd0, if_success}, 32'd0);
        chk("rst_load_success", {31'd0, mem_load_success}, 32'd0);
        chk("rst_store_success", {31'd0, mem_store_success}, 32'd0);
        chk("rst_from_mem_data", from_mem_data, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        #1 rst = 1'b0;
        free_edge = cyc + 1;

        // fetch at 0x100
        if_read_signal = 1'b1; if_addr = 32'h100;
        g = next_grant();
        expect_op(0, g, 5, rd_word(32'h100, 4));
        wait_done(0);
        if_read_signal = 1'b0;
        chk("fetch_latency", 32'(last_pulse[0] - g), 32'd5);
        chk("fetch_word_lit", if_instr, 32'h00000513);

        // IO store held off 3 cycles by a full IO buffer
        start_store(32'h30000, 3'd1, 32'h41);
        io_buffer_full = 1'b1;
        g = next_grant();
        expect_op(2, g, 4, 32'd1);
        wait_until(g + 2);
        io_buffer_full = 1'b0;
        wait_done(2);
        lsb_write_signal = 1'b0;
        chk("io_store_byte_lit", {24'd0, ram[12'h000]}, 32'h41);

        // load and fetch together: load first, fetch after the cool cycle
        if_read_signal = 1'b1; if_addr = 32'h100;
        start_load(32'h200, 3'd2);
        g = next_grant();
        expect_op(1, g, 3, rd_word(32'h200, 2));
        g2 = free_edge;
        expect_op(0, g2, 5, rd_word(32'h100, 4));
        wait_done(1);
        lsb_read_signal = 1'b0;
        wait_done(0);
        if_read_signal = 1'b0;
        chk("lh_word_lit", from_mem_data, 32'h000080FF);
        chk("fetch_after_load_gap", 32'(last_pulse[0] - last_pulse[1]), 32'd7);

        // flush during fetch, then a new fetch at the redirect target
        if_read_signal = 1'b1; if_addr = 32'h100;
        g = next_grant();
        wait_until(g + 1);
        jump_wrong = 1'b1;
        step();
        jump_wrong = 1'b0;
        if_addr = 32'h104;
        free_edge = g + 3;
        g2 = next_grant();
        expect_op(0, g2, 5, rd_word(32'h104, 4));
        wait_done(0);
        if_read_signal = 1'b0;
        chk("redirect_fetch_lit", if_instr, 32'h00100093);

        // store word survives a flush
        start_store(32'h400, 3'd4, 32'hDEADBEEF);
        g = next_grant();
        expect_op(2, g, 4, 32'd4);
        wait_until(g + 1);
        jump_wrong = 1'b1;
        step();
        jump_wrong = 1'b0;
        wait_done(2);
        lsb_write_signal = 1'b0;
        chk("sw_bytes_lit", rd_word(32'h400, 4), 32'hDEADBEEF);

        // single byte load
        start_load(32'h300, 3'd1);
        g = next_grant();
        expect_op(1, g, 2, rd_word(32'h300, 1));
        wait_done(1);
        lsb_read_signal = 1'b0;
        chk("lb_lit", from_mem_data, 32'h000000A5);

        // halfword load wrapping past 0xFFFFFFFF
        start_load(32'hFFFFFFFF, 3'd2);
        g = next_grant();
        expect_op(1, g, 3, rd_word(32'hFFFFFFFF, 2));
        wait_done(1);
        lsb_read_signal = 1'b0;
        chk("wrap_lh_lit", from_mem_data, 32'h00004112);

        // non-IO store ignores the IO back-pressure
        start_store(32'h500, 3'd2, 32'h1234BEEF);
        io_buffer_full = 1'b1;
        g = next_grant();
        expect_op(2, g, 2, 32'd2);
        wait_done(2);
        lsb_write_signal = 1'b0;
        io_buffer_full = 1'b0;
        chk("sh_bytes_lit", rd_word(32'h500, 2), 32'h0000BEEF);

        // rdy dropped mid-read for two cycles
        start_load(32'h200, 3'd4);
        g = next_grant();
        expect_op(1, g, -1, rd_word(32'h200, 4));
        wait_until(g + 2);
        rdy = 1'b0;
        step();
        step();
        rdy = 1'b1;
        wait_done(1);
        lsb_read_signal = 1'b0;
        chk("stalled_lw_lit", from_mem_data, 32'h221180FF);

        // asynchronous reset in the middle of a read
        start_load(32'h400, 3'd4);
        g = next_grant();
        expect_op(1, g, 5, rd_word(32'h400, 4));
        wait_until(g + 2);
        #2 rst = 1'b1;
        #1;
        chk("arst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("arst_mem_a", mem_a, 32'd0);
        chk("arst_load_success", {31'd0, mem_load_success}, 32'd0);
        chk("arst_if_success", {31'd0, if_success}, 32'd0);
        chk("arst_store_success", {31'd0, mem_store_success}, 32'd0);
        chk("arst_from_mem_data", from_mem_data, 32'd0);
        exp_v[0] = 1'b0; exp_v[1] = 1'b0; exp_v[2] = 1'b0;
        step();
        rst = 1'b0;
        free_edge = cyc + 1;
        g = next_grant();
        expect_op(1, g, 5, rd_word(32'h400, 4));
        wait_done(1);
        lsb_read_signal = 1'b0;
        chk("post_rst_lw_latency", 32'(last_pulse[1] - g), 32'd5);
        chk("post_rst_lw_lit", from_mem_data, 32'hDEADBEEF);

        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no end of test, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Single-port memory controller between the 8-bit unified RAM and its two requesters: the instruction fetcher and the load/store buffer (LSB).
- Serialises 1/2/4-byte little-endian accesses into byte transfers.
- Arbitrates with fixed priority: store > load > fetch.
- Returns assembled 32-bit results with a one-cycle success pulse.
- Drops speculative fetch/load work on a mispredict flush; an in-flight store always completes.

Parameters:
IO_ADDR_HI, 2'b11, value of addr[17:16] that marks the memory-mapped IO region (write stall applies).
FETCH_BYTES, 4, bytes per instruction fetch.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
rdy  input  1  global enable; when low, all state and outputs hold
jump_wrong  input  1  mispredict flush
lsb_read_signal  input  1  LSB load request, level, held until mem_load_success
lsb_write_signal  input  1  LSB store request, level, held until mem_store_success
requiring_length  input  3  access size in bytes: 1, 2 or 4
to_mem_addr  input  32  LSB byte address
to_mem_data  input  32  store data, low bytes used
mem_load_success  output  1  one-cycle pulse, load data valid
mem_store_success  output  1  one-cycle pulse, store finished
from_mem_data  output  32  load data, zero-extended
if_read_signal  input  1  fetch request, level
if_addr  input  32  fetch address
if_success  output  1  one-cycle pulse, instruction valid
if_instr  output  32  fetched word
mem_din  input  8  RAM read data (one-cycle latency)
mem_dout  output  8  RAM write data
mem_a  output  32  RAM address
mem_wr  output  1  1 = write, 0 = read
io_buffer_full  input  1  IO write back-pressure

Behaviour:
- Reset (async): state=IDLE; counters=0; mem_a=0, mem_dout=0, mem_wr=0; all success pulses=0; from_mem_data=0, if_instr=0.
- States:
  - IDLE: grant the highest-priority asserted request; latch addr, len (fetch=FETCH_BYTES), data and owner; go to READ or WRITE.
  - READ: issue byte addresses base+0 .. base+len-1 on consecutive cycles, one per cycle. mem_din for the address issued in cycle k is sampled in cycle k+1 into byte lane k. After the last byte is captured: pulse owner's success with the assembled word, then go to COOL.
  - WRITE: per cycle drive mem_wr=1, mem_a=base+k, mem_dout=data[8k+7:8k].
    - If io_buffer_full=1 and addr[17:16]==IO_ADDR_HI: drive mem_wr=0 and do not advance k.
    - After byte len-1 is written: pulse mem_store_success, go to COOL.
  - COOL: one idle cycle (mem_wr=0) so the requester can drop its level request; then IDLE.
- Latency (no stall):
  - N-byte read grant to success pulse = N+1 cycles; lw = 5.
  - N-byte write = N cycles; sw = 4.
- Success pulses last exactly one cycle. Unused upper bytes of from_mem_data are 0. Sign extension is not done here.
- Outside WRITE, mem_wr=0 always. Address arithmetic is 32-bit and wraps modulo 2^32.
- jump_wrong=1 (with rdy):
  - In READ or IDLE: abort, no success pulse, go to IDLE next cycle.
  - In WRITE: the store continues to completion.
  - In COOL: unaffected.
- Simultaneous requests in IDLE: write wins, then read, then fetch. A losing request stays pending with no starvation guarantee.
- A request deasserted before grant is ignored. Inputs are sampled only at grant.
- rdy=0 freezes the counter and state. Byte capture stalls too, and the RAM address is re-issued on resume.

Test Plan:
- Memory holds [0x100..0x103]=13 05 00 00; fetch at 0x100 -> if_success one cycle 5 cycles after grant, if_instr=0x00000513, mem_wr never 1.
- LSB write len=1 addr=0x30000 data=0x41, io_buffer_full=1 for 3 cycles -> mem_wr=0 for 3 cycles, then one write of 0x41; mem_store_success 1 cycle later.
- if_read and lsb_read asserted in same IDLE cycle, lsb lh at 0x200 (bytes FF 80) -> load granted first, from_mem_data=0x000080FF; fetch granted after COOL.
- Fetch in progress, jump_wrong at byte 2 -> no if_success; IDLE next cycle; new fetch at new address completes normally.
- sw 0xDEADBEEF at 0x400, jump_wrong mid-write -> all 4 bytes EF BE AD DE written, mem_store_success pulses.
- rst asserted mid-read, asynchronously between edges -> mem_wr=0, all success outputs 0 immediately; after release, an lw completes in 5 cycles.
